ysyx_24100012_trap_ctrl: RTL and testbench

Trap sequencer that drives the CSR file as its initiator. It accepts one trap or return request from the core: ECALL, EBREAK, illegal instruction, or MRET. It then issues the required CSR reads and writes one per cycle and emits a one-cycle PC redirect to the fetch stage. It sits between the decode/execute stage and the CSR file, and owns all hardware-initiated CSR updates.

---
 rtl/ysyx_24100012_trap_ctrl_pkg.sv | 50 +++++
 rtl/ysyx_24100012_mstatus_upd.sv | 24 ++
 rtl/ysyx_24100012_trap_ctrl.sv | 147 ++++++++++++++
 tb/tb_ysyx_24100012_trap_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24100012_trap_ctrl_pkg.sv
// Shared constants, kind/state encodings and cause lookup for the trap sequencer.
// TRAP_MTVAL_EN adds the TVAL state to the state enum.
package ysyx_24100012_trap_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
    localparam logic [3:0] CAUSE_EBREAK  = 4'd3;
    localparam logic [3:0] CAUSE_ECALL   = 4'd11;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    typedef enum logic [1:0] {
        KIND_ECALL   = 2'b00,
        KIND_EBREAK  = 2'b01,
        KIND_MRET    = 2'b10,
        KIND_ILLEGAL = 2'b11
    } trapKind_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EPC,
        ST_CAUSE,
`ifdef TRAP_MTVAL_EN
        ST_TVAL,
`endif
        ST_STATUS,
        ST_VEC,
        ST_MRET,
        ST_RET
    } trapState_e;

    // MRET never reaches the cause state; it maps to 0 only for completeness.
    function automatic logic [3:0] causeCode(input trapKind_e kind);
        case (kind)
            KIND_ECALL:   causeCode = CAUSE_ECALL;
            KIND_EBREAK:  causeCode = CAUSE_EBREAK;
            KIND_ILLEGAL: causeCode = CAUSE_ILLEGAL;
            default:      causeCode = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_24100012_mstatus_upd.sv
// Combinational mstatus rewrite for trap entry (isReturn=0) and MRET (isReturn=1).
module ysyx_24100012_mstatus_upd
    import ysyx_24100012_trap_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] oldStatus,
    input  logic                  isReturn,
    output logic [DATA_WIDTH-1:0] newStatus
);

    always_comb begin
        newStatus = oldStatus;
        newStatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        if (isReturn) begin
            newStatus[MSTATUS_MIE]  = oldStatus[MSTATUS_MPIE];
            newStatus[MSTATUS_MPIE] = 1'b1;
        end else begin
            newStatus[MSTATUS_MPIE] = oldStatus[MSTATUS_MIE];
            newStatus[MSTATUS_MIE]  = 1'b0;
        end
    end

endmodule

// File: rtl/ysyx_24100012_trap_ctrl.sv
// Trap/MRET sequencer issuing one CSR access per cycle and a one-cycle PC redirect.
// Optional macro TRAP_MTVAL_EN adds an mtval write between mcause and mstatus.
module ysyx_24100012_trap_ctrl
    import ysyx_24100012_trap_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  trap_valid,
    output logic                  trap_ready,
    input  logic [1:0]            trap_kind,
    input  logic [DATA_WIDTH-1:0] trap_pc,
    input  logic [DATA_WIDTH-1:0] trap_tval,
    output logic                  csr_wen,
    output logic [IDX_WIDTH-1:0]  csr_widx,
    output logic [DATA_WIDTH-1:0] csr_wdata,
    output logic [IDX_WIDTH-1:0]  csr_ridx,
    input  logic [DATA_WIDTH-1:0] csr_rdata,
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc
);

    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

    // Handshake: a request transfers on a rising edge where trap_valid && trap_ready;
    // trap_ready is high only in IDLE and inputs are don't-care otherwise.
    trapState_e            state;
    trapState_e            stateNext;
    trapKind_e             latKind;
    logic [DATA_WIDTH-1:0] latPc;
    logic                  accept;
    logic                  statusRet;
    logic [DATA_WIDTH-1:0] statusNew;

`ifdef TRAP_MTVAL_EN
    logic [DATA_WIDTH-1:0] latTval;
`else
    logic                  unusedTval;
    assign unusedTval = ^trap_tval;
`endif

    assign accept = trap_valid && trap_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            latKind <= KIND_ECALL;
            latPc   <= '0;
`ifdef TRAP_MTVAL_EN
            latTval <= '0;
`endif
        end else begin
            state <= stateNext;
            if (accept) begin
                latKind <= trapKind_e'(trap_kind);
                latPc   <= trap_pc;
`ifdef TRAP_MTVAL_EN
                latTval <= trap_tval;
`endif
            end
        end
    end

    ysyx_24100012_mstatus_upd #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mstatus_upd (
        .oldStatus(csr_rdata),
        .isReturn (statusRet),
        .newStatus(statusNew)
    );

    always_comb begin
        stateNext      = state;
        trap_ready     = 1'b0;
        csr_wen        = 1'b0;
        csr_widx       = '0;
        csr_wdata      = '0;
        csr_ridx       = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        statusRet      = 1'b0;
        case (state)
            ST_IDLE: begin
                trap_ready = 1'b1;
                if (trap_valid) begin
                    stateNext = (trapKind_e'(trap_kind) == KIND_MRET) ? ST_MRET : ST_EPC;
                end
            end
            ST_EPC: begin
                csr_wen   = 1'b1;
                csr_widx  = IDX_WIDTH'(CSR_MEPC);
                csr_wdata = latPc & ALIGN_MASK;
                stateNext = ST_CAUSE;
            end
            ST_CAUSE: begin
                csr_wen   = 1'b1;
                csr_widx  = IDX_WIDTH'(CSR_MCAUSE);
                csr_wdata = DATA_WIDTH'(causeCode(latKind));
`ifdef TRAP_MTVAL_EN
                stateNext = ST_TVAL;
`else
                stateNext = ST_STATUS;
`endif
            end
`ifdef TRAP_MTVAL_EN
            ST_TVAL: begin
                csr_wen   = 1'b1;
                csr_widx  = IDX_WIDTH'(CSR_MTVAL);
                csr_wdata = (latKind == KIND_ILLEGAL) ? latTval : '0;
                stateNext = ST_STATUS;
            end
`endif
            ST_STATUS: begin
                csr_ridx  = IDX_WIDTH'(CSR_MSTATUS);
                csr_wen   = 1'b1;
                csr_widx  = IDX_WIDTH'(CSR_MSTATUS);
                csr_wdata = statusNew;
                stateNext = ST_VEC;
            end
            ST_VEC: begin
                // Direct mode only: mtvec mode bits are dropped.
                csr_ridx       = IDX_WIDTH'(CSR_MTVEC);
                redirect_valid = 1'b1;
                redirect_pc    = csr_rdata & ALIGN_MASK;
                stateNext      = ST_IDLE;
            end
            ST_MRET: begin
                statusRet = 1'b1;
                csr_ridx  = IDX_WIDTH'(CSR_MSTATUS);
                csr_wen   = 1'b1;
                csr_widx  = IDX_WIDTH'(CSR_MSTATUS);
                csr_wdata = statusNew;
                stateNext = ST_RET;
            end
            ST_RET: begin
                csr_ridx       = IDX_WIDTH'(CSR_MEPC);
                redirect_valid = 1'b1;
                redirect_pc    = csr_rdata & ALIGN_MASK;
                stateNext      = ST_IDLE;
            end
            default: stateNext = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ysyx_24100012_trap_ctrl.sv
// Bench for ysyx_24100012_trap_ctrl: CSR file fixture, per-cycle expected-output scoreboard,
// directed scenarios and randomized requests; honours TRAP_MTVAL_EN.
module tb_ysyx_24100012_trap_ctrl;

    localparam int DW = 32;
    localparam int IW = 12;
    localparam int EW = 1 + IW + DW + IW + 1 + DW;

    localparam logic [IW-1:0] A_MSTATUS = 12'h300;
    localparam logic [IW-1:0] A_MTVEC   = 12'h305;
    localparam logic [IW-1:0] A_MEPC    = 12'h341;
    localparam logic [IW-1:0] A_MCAUSE  = 12'h342;
    localparam logic [IW-1:0] A_MTVAL   = 12'h343;

`ifdef TRAP_MTVAL_EN
    localparam int TRAP_LAT = 5;
`else
    localparam int TRAP_LAT = 4;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic          trap_valid;
    logic          trap_ready;
    logic [1:0]    trap_kind;
    logic [DW-1:0] trap_pc;
    logic [DW-1:0] trap_tval;
    logic          csr_wen;
    logic [IW-1:0] csr_widx;
    logic [DW-1:0] csr_wdata;
    logic [IW-1:0] csr_ridx;
    logic [DW-1:0] csr_rdata;
    logic          redirect_valid;
    logic [DW-1:0] redirect_pc;

    always #5 clk = ~clk;

    ysyx_24100012_trap_ctrl #(.DATA_WIDTH(DW), .IDX_WIDTH(IW)) dut (
        .clk           (clk),
        .rst           (rst),
        .trap_valid    (trap_valid),
        .trap_ready    (trap_ready),
        .trap_kind     (trap_kind),
        .trap_pc       (trap_pc),
        .trap_tval     (trap_tval),
        .csr_wen       (csr_wen),
        .csr_widx      (csr_widx),
        .csr_wdata     (csr_wdata),
        .csr_ridx      (csr_ridx),
        .csr_rdata     (csr_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
    );

    // ---------------- CSR file fixture ----------------
    logic [DW-1:0] csrMem [0:4095] = '{default: '0};
    logic          pokeEn = 1'b0;
    logic [IW-1:0] pokeIdx = '0;
    logic [DW-1:0] pokeData = '0;

    always_comb csr_rdata = csrMem[csr_ridx];

    always @(posedge clk) begin
        if (csr_wen) csrMem[csr_widx] <= csr_wdata;
        if (pokeEn) csrMem[pokeIdx] <= pokeData;
    end

    // ---------------- checking ----------------
    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // ---------------- reference model ----------------
    logic [EW-1:0] exp_q[$];

    function automatic logic [EW-1:0] ev(input logic w, input logic [IW-1:0] wi,
                                         input logic [DW-1:0] wd, input logic [IW-1:0] ri,
                                         input logic rv, input logic [DW-1:0] rp);
        return {w, wi, wd, ri, rv, rp};
    endfunction

    function automatic logic [DW-1:0] enterStatus(input logic [DW-1:0] old);
        return (old & ~32'h1888) | (((old >> 3) & 32'd1) << 7) | 32'h1800;
    endfunction

    function automatic logic [DW-1:0] retStatus(input logic [DW-1:0] old);
        return (old & ~32'h1888) | (((old >> 7) & 32'd1) << 3) | 32'h80 | 32'h1800;
    endfunction

    // CSRs read by a sequence are never written earlier in that same sequence,
    // so the whole expected trace can be computed at acceptance time.
    function automatic void pushSeq(input logic [1:0] k, input logic [DW-1:0] pc,
                                    input logic [DW-1:0] tv);
        logic [DW-1:0] cause;
        if (k == 2'b10) begin
            exp_q.push_back(ev(1'b1, A_MSTATUS, retStatus(csrMem[A_MSTATUS]), A_MSTATUS, 1'b0, '0));
            exp_q.push_back(ev(1'b0, '0, '0, A_MEPC, 1'b1, csrMem[A_MEPC] & ~32'h3));
        end else begin
            cause = (k == 2'b00) ? 32'd11 : (k == 2'b01) ? 32'd3 : 32'd2;
            exp_q.push_back(ev(1'b1, A_MEPC, pc & ~32'h3, '0, 1'b0, '0));
            exp_q.push_back(ev(1'b1, A_MCAUSE, cause, '0, 1'b0, '0));
`ifdef TRAP_MTVAL_EN
            exp_q.push_back(ev(1'b1, A_MTVAL, (k == 2'b11) ? tv : '0, '0, 1'b0, '0));
`else
            if (tv == 32'h0 && tv != 32'h0) exp_q.push_back('0);
`endif
            exp_q.push_back(ev(1'b1, A_MSTATUS, enterStatus(csrMem[A_MSTATUS]), A_MSTATUS, 1'b0, '0));
            exp_q.push_back(ev(1'b0, '0, '0, A_MTVEC, 1'b1, csrMem[A_MTVEC] & ~32'h3));
        end
    endfunction

    // ---------------- monitor ----------------
    logic          monOn = 1'b0;
    int            cyc = 0;
    int            accCyc = 0;
    int            lastLat = 0;
    logic [DW-1:0] lastRpc = '0;
    int            redirCnt = 0;
    int            acceptCnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [EW-1:0] obs;
        logic [EW-1:0] e;
        if (monOn) begin
            obs = {csr_wen, csr_widx, csr_wdata, csr_ridx, redirect_valid, redirect_pc};
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("seq_out", obs, e);
                chk("ready_busy", trap_ready, 1'b0);
            end else begin
                chk("idle_out", obs, '0);
                chk("ready_idle", trap_ready, 1'b1);
            end
            if (redirect_valid) begin
                redirCnt++;
                lastLat = cyc - accCyc;
                lastRpc = redirect_pc;
            end
            if (rst) begin
                exp_q.delete();
            end else if (trap_valid && trap_ready) begin
                acceptCnt++;
                accCyc = cyc;
                pushSeq(trap_kind, trap_pc, trap_tval);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pokeCsr(input logic [IW-1:0] idx, input logic [DW-1:0] data);
        pokeEn = 1'b1;
        pokeIdx = idx;
        pokeData = data;
        @(posedge clk);
        #1 pokeEn = 1'b0;
    endtask

    task automatic sendReq(input logic [1:0] k, input logic [DW-1:0] pc,
                           input logic [DW-1:0] tv, output int waited);
        int n = 0;
        trap_valid = 1'b1;
        trap_kind = k;
        trap_pc = pc;
        trap_tval = tv;
        @(negedge clk);
        while (!trap_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) chk("accept_timeout", 1'b1, 1'b0);
        waited = n;
        @(posedge clk);
        #1;
        trap_valid = 1'b0;
        trap_kind = 2'($urandom_range(0, 3));
        trap_pc = $urandom;
        trap_tval = $urandom;
    endtask

    task automatic waitIdle();
        int n = 0;
        @(negedge clk);
        while ((!trap_ready || exp_q.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("idle_timeout", 1'b1, 1'b0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w;
        int snapRedir;
        int snapAcc;
        rst = 1'b1;
        trap_valid = 1'b0;
        trap_kind = 2'b00;
        trap_pc = '0;
        trap_tval = '0;
        repeat (2) @(posedge clk);
        #1 monOn = 1'b1;
        @(negedge clk);
        chk("rst_ready", trap_ready, 1'b1);
        chk("rst_wen", csr_wen, 1'b0);
        chk("rst_redirect", redirect_valid, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        // ECALL
        pokeCsr(A_MTVEC, 32'h80000101);
        pokeCsr(A_MSTATUS, 32'h8);
        sendReq(2'b00, 32'h80000010, 32'h0, w);
        waitIdle();
        chk("ecall_mepc", csrMem[A_MEPC], 32'h80000010);
        chk("ecall_mcause", csrMem[A_MCAUSE], 32'hb);
        chk("ecall_mstatus", csrMem[A_MSTATUS], 32'h1880);
        chk("ecall_rpc", lastRpc, 32'h80000100);
        chk("ecall_lat", lastLat, TRAP_LAT);

        // MRET
        pokeCsr(A_MEPC, 32'h80000014);
        sendReq(2'b10, 32'h0, 32'h0, w);
        waitIdle();
        chk("mret_mstatus", csrMem[A_MSTATUS], 32'h1888);
        chk("mret_rpc", lastRpc, 32'h80000014);
        chk("mret_lat", lastLat, 2);

        // ILLEGAL with all-ones tval
        sendReq(2'b11, 32'h80000022, 32'hffffffff, w);
        waitIdle();
        chk("ill_mcause", csrMem[A_MCAUSE], 32'h2);
        chk("ill_mepc", csrMem[A_MEPC], 32'h80000020);
`ifdef TRAP_MTVAL_EN
        chk("ill_mtval", csrMem[A_MTVAL], 32'hffffffff);
`else
        chk("ill_mtval", csrMem[A_MTVAL], 32'h0);
`endif
        chk("ill_lat", lastLat, TRAP_LAT);

        // MRET held valid during an ECALL sequence
        pokeCsr(A_MSTATUS, 32'h8);
        pokeCsr(A_MEPC, 32'h0);
        snapAcc = acceptCnt;
        sendReq(2'b00, 32'h80000030, 32'h0, w);
        sendReq(2'b10, 32'h0, 32'h0, w);
        chk("busy_wait", w, TRAP_LAT);
        waitIdle();
        chk("busy_accepts", acceptCnt - snapAcc, 2);
        chk("busy_mret_lat", lastLat, 2);
        chk("busy_mstatus", csrMem[A_MSTATUS], 32'h1888);
        chk("busy_rpc", lastRpc, 32'h80000030);

        // Reset while in CAUSE
        pokeCsr(A_MSTATUS, 32'h8);
        snapRedir = redirCnt;
        sendReq(2'b00, 32'h80000040, 32'h0, w);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready", trap_ready, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_mstatus", csrMem[A_MSTATUS], 32'h8);
        chk("midrst_mepc", csrMem[A_MEPC], 32'h80000040);
        chk("midrst_redirects", redirCnt - snapRedir, 0);

        // Randomized requests
        for (int i = 0; i < 40; i++) begin
            pokeCsr(A_MSTATUS, $urandom);
            pokeCsr(A_MTVEC, $urandom);
            pokeCsr(A_MEPC, $urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            sendReq(2'($urandom_range(0, 3)), $urandom, $urandom, w);
            if ($urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
            end
            waitIdle();
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
